// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches words from instruction memory over a request/ready handshake.
// A one-entry last-address buffer skips memory on a repeated PC; a watchdog replaces silent fetches with a NOP.
module instruction_fetch_unit #(
   parameter int                   BUS_WIDTH = 16,
   parameter int                   TIMEOUT   = 16,
   parameter logic [BUS_WIDTH-1:0] NOP_INSTR = 16'h0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] PC,
   input  logic                 fetchReq,
   input  logic                 flush,
   output logic [BUS_WIDTH-1:0] IR,
   output logic                 irValid,
   output logic                 busy,
   output logic                 fetchError,
   output logic [BUS_WIDTH-1:0] memAddr,
   output logic                 memRead,
   input  logic                 memReady,
   input  logic [BUS_WIDTH-1:0] memData
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]           state_q,      state_d;
   logic [BUS_WIDTH-1:0] ir_q,         ir_d;
   logic                 irValid_q,    irValid_d;
   logic                 busy_q,       busy_d;
   logic                 fetchError_q, fetchError_d;
   logic [BUS_WIDTH-1:0] memAddr_q,    memAddr_d;
   logic                 memRead_q,    memRead_d;
   logic [BUS_WIDTH-1:0] tagAddr_q,    tagAddr_d;
   logic                 tagValid_q,   tagValid_d;
   logic                 nocache_q,    nocache_d;
   logic [CW-1:0]        count_q,      count_d;

   logic                 tagHit;

   // A flush arriving with the request forces a miss even when the tag matches.
   assign tagHit = tagValid_q && (PC == tagAddr_q) && !flush;

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      irValid_d    = 1'b0;
      busy_d       = busy_q;
      fetchError_d = fetchError_q;
      memAddr_d    = memAddr_q;
      memRead_d    = memRead_q;
      tagAddr_d    = tagAddr_q;
      tagValid_d   = tagValid_q;
      nocache_d    = nocache_q;
      count_d      = count_q;

      case (state_q)
         IDLE: begin
            if (flush) begin
               tagValid_d = 1'b0;
            end
            if (fetchReq) begin
               if (tagHit) begin
                  irValid_d = 1'b1;
               end else begin
                  memAddr_d = PC;
                  memRead_d = 1'b1;
                  busy_d    = 1'b1;
                  count_d   = '0;
                  nocache_d = flush;
                  state_d   = WAIT;
               end
            end
         end

         WAIT: begin
            // memReady is checked first so a reply on the last watchdog cycle still completes normally.
            if (memReady) begin
               ir_d       = memData;
               irValid_d  = 1'b1;
               memRead_d  = 1'b0;
               busy_d     = 1'b0;
               tagAddr_d  = memAddr_q;
               tagValid_d = !(nocache_q || flush);
               state_d    = IDLE;
            end else if (count_q == CNT_LAST) begin
               ir_d         = NOP_INSTR;
               irValid_d    = 1'b1;
               fetchError_d = 1'b1;
               tagValid_d   = 1'b0;
               memRead_d    = 1'b0;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end else begin
               count_d = count_q + CW'(1);
               if (flush) begin
                  nocache_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ir_q         <= NOP_INSTR;
         irValid_q    <= 1'b0;
         busy_q       <= 1'b0;
         fetchError_q <= 1'b0;
         memAddr_q    <= '0;
         memRead_q    <= 1'b0;
         tagAddr_q    <= '0;
         tagValid_q   <= 1'b0;
         nocache_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         irValid_q    <= irValid_d;
         busy_q       <= busy_d;
         fetchError_q <= fetchError_d;
         memAddr_q    <= memAddr_d;
         memRead_q    <= memRead_d;
         tagAddr_q    <= tagAddr_d;
         tagValid_q   <= tagValid_d;
         nocache_q    <= nocache_d;
         count_q      <= count_d;
      end
   end

   assign IR         = ir_q;
   assign irValid    = irValid_q;
   assign busy       = busy_q;
   assign fetchError = fetchError_q;
   assign memAddr    = memAddr_q;
   assign memRead    = memRead_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: table of fetch transactions plus directed reset/hold sequences.
// Expected IR words go into a queue when a request is driven and are popped whenever irValid is seen.
module tb_instruction_fetch_unit;

   localparam int          W   = 16;
   localparam int          TO  = 16;
   localparam logic [15:0] NOP = 16'h0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  PC = '0;
   logic          fetchReq = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  IR;
   logic          irValid;
   logic          busy;
   logic          fetchError;
   logic [W-1:0]  memAddr;
   logic          memRead;
   logic          memReady = 1'b0;
   logic [W-1:0]  memData = '0;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] sbQ[$];

   typedef struct {
      logic [15:0] pc;
      logic        flush;
      logic        flushWait;
      logic        resetFirst;
      int          latency;
      logic [15:0] data;
      logic        expHit;
      logic [15:0] expIR;
      logic        expErr;
   } vec_t;

   vec_t vecs[13];

   instruction_fetch_unit #(
      .BUS_WIDTH(W),
      .TIMEOUT(TO),
      .NOP_INSTR(NOP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .PC(PC),
      .fetchReq(fetchReq),
      .flush(flush),
      .IR(IR),
      .irValid(irValid),
      .busy(busy),
      .fetchError(fetchError),
      .memAddr(memAddr),
      .memRead(memRead),
      .memReady(memReady),
      .memData(memData)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Every irValid strobe must match the oldest outstanding expected word.
   always @(negedge clk) begin
      if (irValid) begin
         total++;
         if (sbQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: irValid with IR=%h but nothing expected", IR);
         end else begin
            logic [W-1:0] exp;
            exp = sbQ.pop_front();
            if (IR !== exp) begin
               bad++;
               $display("[TB] FAIL scoreboard IR: got %h want %h", IR, exp);
            end
         end
      end
   end

   task automatic doReset();
      reset    = 1'b1;
      fetchReq = 1'b0;
      flush    = 1'b0;
      memReady = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      int   w;
      int   reads;
      logic done;
      if (v.resetFirst) doReset();
      PC       = v.pc;
      fetchReq = 1'b1;
      flush    = v.flush;
      sbQ.push_back(v.expIR);
      @(posedge clk); #1;
      fetchReq = 1'b0;
      flush    = 1'b0;
      if (v.expHit) begin
         checkOutput("hit memRead", {31'd0, memRead}, 32'd0);
         checkOutput("hit irValid", {31'd0, irValid}, 32'd1);
         checkOutput("hit IR", {16'd0, IR}, {16'd0, v.expIR});
      end else begin
         reads = 0;
         w     = 1;
         done  = 1'b0;
         while (!done && w <= TO + 4) begin
            if (memRead) begin
               reads++;
               checkOutput("memAddr held", {16'd0, memAddr}, {16'd0, v.pc});
            end
            checkOutput("busy in wait", {31'd0, busy}, 32'd1);
            if (w == 1 && v.flushWait) flush = 1'b1;
            if (w == v.latency) begin
               memReady = 1'b1;
               memData  = v.data;
            end
            @(posedge clk); #1;
            memReady = 1'b0;
            memData  = '0;
            flush    = 1'b0;
            if (irValid) done = 1'b1;
            else w++;
         end
         checkOutput("fetch completed", {31'd0, done}, 32'd1);
         checkOutput("memRead cycles", reads, (v.latency == 0) ? TO : v.latency);
         checkOutput("memRead low after", {31'd0, memRead}, 32'd0);
         checkOutput("busy low after", {31'd0, busy}, 32'd0);
         checkOutput("miss IR", {16'd0, IR}, {16'd0, v.expIR});
      end
      checkOutput("fetchError", {31'd0, fetchError}, {31'd0, v.expErr});
      @(posedge clk); #1;
      checkOutput("single strobe", {31'd0, irValid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global time limit: got running want finished");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      //            pc        fl    flW   rst   lat data      hit   expIR     err
      vecs[0]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 3,  16'h1234, 1'b0, 16'h1234, 1'b0};
      vecs[1]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 0,  16'h0000, 1'b1, 16'h1234, 1'b0};
      vecs[2]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 1,  16'h5678, 1'b0, 16'h5678, 1'b0};
      vecs[3]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 2,  16'h1111, 1'b0, 16'h1111, 1'b0};
      vecs[4]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 0,  16'h0000, 1'b1, 16'h1111, 1'b0};
      vecs[5]  = '{16'h0020, 1'b0, 1'b0, 1'b0, 1,  16'hA5A5, 1'b0, 16'hA5A5, 1'b0};
      vecs[6]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 2,  16'h2222, 1'b0, 16'h2222, 1'b0};
      vecs[7]  = '{16'h0030, 1'b0, 1'b0, 1'b0, 0,  16'h0000, 1'b0, NOP,      1'b1};
      vecs[8]  = '{16'h0030, 1'b0, 1'b0, 1'b0, 4,  16'h3333, 1'b0, 16'h3333, 1'b1};
      vecs[9]  = '{16'h0040, 1'b0, 1'b0, 1'b1, 16, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
      vecs[10] = '{16'h0040, 1'b0, 1'b0, 1'b0, 0,  16'h0000, 1'b1, 16'hBEEF, 1'b0};
      vecs[11] = '{16'h0070, 1'b0, 1'b1, 1'b0, 2,  16'h7777, 1'b0, 16'h7777, 1'b0};
      vecs[12] = '{16'h0070, 1'b0, 1'b0, 1'b0, 1,  16'h7878, 1'b0, 16'h7878, 1'b0};

      doReset();
      checkOutput("reset IR", {16'd0, IR}, {16'd0, NOP});
      checkOutput("reset irValid", {31'd0, irValid}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset memRead", {31'd0, memRead}, 32'd0);
      checkOutput("reset fetchError", {31'd0, fetchError}, 32'd0);
      checkOutput("reset memAddr", {16'd0, memAddr}, 32'd0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
      end

      // Reset while waiting on memory, then a stale reply that must be ignored.
      PC       = 16'h0050;
      fetchReq = 1'b1;
      @(posedge clk); #1;
      fetchReq = 1'b0;
      checkOutput("rstwait memRead up", {31'd0, memRead}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("rstwait memRead dropped", {31'd0, memRead}, 32'd0);
      checkOutput("rstwait busy dropped", {31'd0, busy}, 32'd0);
      memReady = 1'b1;
      memData  = 16'hDEAD;
      @(posedge clk); #1;
      memReady = 1'b0;
      memData  = '0;
      checkOutput("late ready irValid", {31'd0, irValid}, 32'd0);
      checkOutput("late ready IR", {16'd0, IR}, {16'd0, NOP});
      @(posedge clk); #1;
      checkOutput("late ready irValid 2", {31'd0, irValid}, 32'd0);

      // fetchReq held across the whole wait must not start a second transaction.
      PC       = 16'h0060;
      fetchReq = 1'b1;
      sbQ.push_back(16'h6666);
      @(posedge clk); #1;
      checkOutput("held memRead c1", {31'd0, memRead}, 32'd1);
      @(posedge clk); #1;
      checkOutput("held memRead c2", {31'd0, memRead}, 32'd1);
      checkOutput("held memAddr", {16'd0, memAddr}, 32'h0060);
      memReady = 1'b1;
      memData  = 16'h6666;
      fetchReq = 1'b0;
      @(posedge clk); #1;
      memReady = 1'b0;
      memData  = '0;
      checkOutput("held irValid", {31'd0, irValid}, 32'd1);
      checkOutput("held memRead low", {31'd0, memRead}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checkOutput("held no second read", {31'd0, memRead}, 32'd0);
         checkOutput("held no second strobe", {31'd0, irValid}, 32'd0);
      end

      checkOutput("scoreboard drained", sbQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetches 16-bit instruction words from instruction memory for the CPU controller. Takes the program counter `PC` and a fetch request, runs a request/ready handshake with instruction memory, and presents the fetched word on `IR` with a one-cycle `irValid` strobe. Holds a single-entry last-address buffer so re-fetching the same `PC` skips the memory access. Includes a watchdog that substitutes a NOP and flags an error if memory never answers.

## Interface
Parameters:
- `BUS_WIDTH`, 16, instruction and address width
- `TIMEOUT`, 16, maximum WAIT cycles before abort (≥2)
- `NOP_INSTR`, 16'h0000, word substituted on timeout and driven after reset

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `PC`  in  BUS_WIDTH  instruction address from controller
- `fetchReq`  in  1  request the instruction at `PC` (sampled only in IDLE)
- `flush`  in  1  invalidate the last-address buffer (e.g. after a memory write)
- `IR`  out  BUS_WIDTH  fetched instruction, registered, stable between fetches
- `irValid`  out  1  one-cycle strobe: `IR` was updated or confirmed this cycle
- `busy`  out  1  high while in WAIT
- `fetchError`  out  1  sticky timeout flag
- `memAddr`  out  BUS_WIDTH  instruction memory address, registered
- `memRead`  out  1  read request to memory, registered
- `memReady`  in  1  memory has `memData` valid this cycle
- `memData`  in  BUS_WIDTH  instruction word from memory

## Operation
- Internal state: FSM {IDLE, WAIT}, `tagAddr[BUS_WIDTH]`, `tagValid`, `nocache` bit, timeout counter of `$clog2(TIMEOUT)` bits.
- Reset, sync and active-high, has priority over everything: state IDLE. Outputs: `IR` = NOP_INSTR, `irValid` = 0, `busy` = 0, `fetchError` = 0, `memRead` = 0, `memAddr` = 0. Internal: `tagValid` = 0, counter = 0, `nocache` = 0.
- IDLE, `fetchReq` = 1:
  - Hit (`tagValid` and `PC` == `tagAddr` and not `flush`): `IR` is unchanged and `irValid` = 1 next cycle. Stay IDLE.
  - Miss: `memAddr` ← `PC`, `memRead` ← 1, `busy` ← 1, counter ← 0, `nocache` ← `flush`. Go to WAIT.
- IDLE, `flush` = 1: `tagValid` ← 0. When `flush` and `fetchReq` arrive together, the request is treated as a miss.
- WAIT: `memRead` and `memAddr` are held stable. `fetchReq` is ignored (no queueing).
  - `memReady` = 1: `IR` ← `memData`, `irValid` ← 1, `memRead` ← 0, `busy` ← 0, `tagAddr` ← `memAddr`, `tagValid` ← not (`nocache` or `flush`). Go to IDLE.
  - `memReady` = 0 and counter == TIMEOUT-1: `IR` ← NOP_INSTR, `irValid` ← 1, `fetchError` ← 1, `tagValid` ← 0, `memRead` ← 0, `busy` ← 0. Go to IDLE.
  - Otherwise: counter increments. A `flush` here sets `nocache`.
  - `memReady` on the same cycle the counter reaches TIMEOUT-1: `memReady` wins and this is a normal completion.
- `memReady` in IDLE is ignored.
- `fetchError` clears only on reset.
- `irValid` is never high for two consecutive cycles from a single request.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- Hit: `fetchReq` at edge 0 → `irValid` high during cycle 1.
- Miss: `fetchReq` at edge 0 → `memRead` high from cycle 1. `memReady` sampled at edge k → `IR` and `irValid` valid in cycle k+1, `memRead` low in cycle k+1. Minimum miss latency is 2 cycles.
- Timeout: with no `memReady`, `memRead` stays high for exactly TIMEOUT cycles. `irValid` with NOP follows in the next cycle.
- A new request is accepted on the cycle `irValid` is high, because the FSM is already in IDLE. Back-to-back miss throughput is 1 instruction per 2 cycles at zero memory wait.
- Reset mid-WAIT: the next cycle has `memRead` = 0. A late `memReady` is ignored.

## Test plan
- Reset, then check outputs: `IR` = 0000, `irValid`/`busy`/`memRead`/`fetchError` = 0, `memAddr` = 0.
- Miss with 3-cycle memory: PC=0x0010, `fetchReq` pulse; drive `memReady` with `memData` = 0x1234 on the 3rd WAIT cycle. Expect `memAddr` = 0x0010 held, `IR` = 0x1234, a single `irValid` strobe, `busy` low afterwards.
- Hit then flush:
  - Repeat PC=0x0010: expect `irValid` after 1 cycle, no `memRead`, `IR` = 0x1234.
  - Assert `flush` together with `fetchReq`: expect a full memory access.
- Timeout with TIMEOUT=16 and memory silent: expect `memRead` high for exactly 16 cycles, then `IR` = NOP_INSTR, `irValid` = 1, `fetchError` = 1 (sticky). Confirm a repeat PC misses.
- Race: `memReady` with `memData` = 0xBEEF on the 16th WAIT cycle. Expect `IR` = 0xBEEF and `fetchError` = 0.
- Disturbances:
  - Reset asserted in WAIT: `memRead` drops next cycle and a following `memReady` produces no `irValid`.
  - `fetchReq` held during WAIT: no second `memRead` transaction is started.
